mem_bus_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction-cache controller and the data-cache controller.
- Each cycle it forwards at most one BUS_LOAD/BUS_STORE command. It records which requester owns each returned transaction tag, and steers the later data/tag completion back to that requester.
- Sits between both cache controllers and the memory model, at the top level of the processor.
- Dcache is favoured; a starvation counter bounds how long the Icache can be held off.

---
 rtl/mem_bus_arbiter_pkg.sv | 13 +
 rtl/mem_tag_owner_table.sv | 54 +++++
 rtl/mem_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter and both cache controllers.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_e;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Records which requester owns each outstanding memory tag.
// A set and a clear may land in the same cycle; the set wins when both hit the same tag.
module mem_tag_owner_table #(
  parameter int TAG_BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                set_en,
  input  logic [TAG_BITS-1:0] set_tag,
  input  logic                set_owner,
  input  logic                clr_en,
  input  logic [TAG_BITS-1:0] clr_tag,
  input  logic [TAG_BITS-1:0] rd_tag,
  output logic                rd_valid,
  output logic                rd_owner,
  input  logic [TAG_BITS-1:0] probe_tag,
  output logic                probe_valid,
  output logic [TAG_BITS:0]   outstanding
);

  localparam int ENTRIES = 1 << TAG_BITS;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] owner_q;

  // Clear first, then set, so a reissued tag survives its own completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      if (clr_en) begin
        valid_q[clr_tag] <= 1'b0;
      end
      if (set_en) begin
        valid_q[set_tag] <= 1'b1;
        owner_q[set_tag] <= set_owner;
      end
    end
  end

  assign rd_valid    = valid_q[rd_tag];
  assign rd_owner    = owner_q[rd_tag];
  assign probe_valid = valid_q[probe_tag];

  // Count of live entries, derived straight from the registered valid bits.
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      outstanding = outstanding + (TAG_BITS+1)'(valid_q[i]);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the main-memory port between the Icache and Dcache controllers.
// Dcache is favoured; a starvation counter forces an Icache win after a bounded wait.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TAG_BITS     = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_BITS     = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          Icache2mem_command,
  input  logic [63:0]         Icache2mem_addr,
  input  logic [1:0]          Dcache2mem_command,
  input  logic [63:0]         Dcache2mem_addr,
  input  logic [63:0]         Dcache2mem_data,
  output logic [1:0]          proc2mem_command,
  output logic [63:0]         proc2mem_addr,
  output logic [63:0]         proc2mem_data,
  input  logic [TAG_BITS-1:0] mem2proc_response,
  input  logic [63:0]         mem2proc_data,
  input  logic [TAG_BITS-1:0] mem2proc_tag,
  output logic [TAG_BITS-1:0] mem2Icache_response,
  output logic [63:0]         mem2Icache_data,
  output logic [TAG_BITS-1:0] mem2Icache_tag,
  output logic [TAG_BITS-1:0] mem2Dcache_response,
  output logic [63:0]         mem2Dcache_data,
  output logic [TAG_BITS-1:0] mem2Dcache_tag,
  output logic [TAG_BITS:0]   arb_outstanding,
  output logic                arb_idle,
  output logic                arb_protocol_err
);

  logic [CNT_BITS-1:0] starve_cnt;
  logic                icache_req;
  logic                dcache_req;
  logic                starved;
  logic                grant_icache;
  logic                grant_dcache;
  logic                accepted;
  logic                set_en;
  logic                set_owner;
  logic                comp_valid;
  logic                comp_hit;
  logic                rd_valid;
  logic                rd_owner;
  logic                probe_valid;
  logic                err_now;

  // Requests are masked while reset is held so every output sits at its idle value.
  assign icache_req = !reset && (Icache2mem_command == BUS_LOAD);
  assign dcache_req = !reset && ((Dcache2mem_command == BUS_LOAD) ||
                                 (Dcache2mem_command == BUS_STORE));
  assign starved      = (starve_cnt >= CNT_BITS'(STARVE_LIMIT));
  assign grant_icache = icache_req && (!dcache_req || starved);
  assign grant_dcache = dcache_req && !grant_icache;

  // Forward the winner's command onto the memory port, or an all-zero idle command.
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (grant_icache) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = Icache2mem_addr;
    end else if (grant_dcache) begin
      proc2mem_command = Dcache2mem_command;
      proc2mem_addr    = Dcache2mem_addr;
      proc2mem_data    = Dcache2mem_data;
    end
  end

  assign accepted            = (grant_icache || grant_dcache) && (mem2proc_response != '0);
  assign mem2Icache_response = grant_icache ? mem2proc_response : '0;
  assign mem2Dcache_response = grant_dcache ? mem2proc_response : '0;

  assign set_en    = accepted && (proc2mem_command == BUS_LOAD);
  assign set_owner = grant_dcache ? REQ_DCACHE : REQ_ICACHE;

  assign comp_valid = !reset && (mem2proc_tag != '0);
  assign comp_hit   = comp_valid && rd_valid;

  assign mem2Icache_data = mem2proc_data;
  assign mem2Dcache_data = mem2proc_data;
  assign mem2Icache_tag  = (comp_hit && (rd_owner == REQ_ICACHE)) ? mem2proc_tag : '0;
  assign mem2Dcache_tag  = (comp_hit && (rd_owner == REQ_DCACHE)) ? mem2proc_tag : '0;

  mem_tag_owner_table #(
    .TAG_BITS(TAG_BITS)
  ) u_table (
    .clock      (clock),
    .reset      (reset),
    .set_en     (set_en),
    .set_tag    (mem2proc_response),
    .set_owner  (set_owner),
    .clr_en     (comp_hit),
    .clr_tag    (mem2proc_tag),
    .rd_tag     (mem2proc_tag),
    .rd_valid   (rd_valid),
    .rd_owner   (rd_owner),
    .probe_tag  (mem2proc_response),
    .probe_valid(probe_valid),
    .outstanding(arb_outstanding)
  );

  // A completion for an unknown tag, or a load landing on a live tag that is not retiring now.
  assign err_now = (comp_valid && !rd_valid) ||
                   (set_en && probe_valid && !(comp_hit && (mem2proc_tag == mem2proc_response)));

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      arb_protocol_err <= 1'b0;
    end else if (err_now) begin
      arb_protocol_err <= 1'b1;
    end
  end

  // Count consecutive Icache denials, saturating at the limit; any Icache acceptance clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (icache_req) begin
      if (grant_icache && accepted) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign arb_idle = (arb_outstanding == '0) && !icache_req && !dcache_req;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter against a table-level reference model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int TAG_BITS     = 4;
  localparam int STARVE_LIMIT = 4;
  localparam int CNT_BITS     = 3;
  localparam int ENTRIES      = 1 << TAG_BITS;

  logic                clock;
  logic                reset;
  logic [1:0]          Icache2mem_command;
  logic [63:0]         Icache2mem_addr;
  logic [1:0]          Dcache2mem_command;
  logic [63:0]         Dcache2mem_addr;
  logic [63:0]         Dcache2mem_data;
  logic [1:0]          proc2mem_command;
  logic [63:0]         proc2mem_addr;
  logic [63:0]         proc2mem_data;
  logic [TAG_BITS-1:0] mem2proc_response;
  logic [63:0]         mem2proc_data;
  logic [TAG_BITS-1:0] mem2proc_tag;
  logic [TAG_BITS-1:0] mem2Icache_response;
  logic [63:0]         mem2Icache_data;
  logic [TAG_BITS-1:0] mem2Icache_tag;
  logic [TAG_BITS-1:0] mem2Dcache_response;
  logic [63:0]         mem2Dcache_data;
  logic [TAG_BITS-1:0] mem2Dcache_tag;
  logic [TAG_BITS:0]   arb_outstanding;
  logic                arb_idle;
  logic                arb_protocol_err;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: which tags are live, who owns them, how long the Icache has waited.
  bit m_valid[ENTRIES];
  bit m_owner[ENTRIES];
  int m_starve;
  bit m_err;

  logic [63:0]         obs_addr;
  logic [63:0]         obs_p2m_data;
  logic [63:0]         obs_dc_data;
  logic [TAG_BITS-1:0] obs_itag;
  logic [TAG_BITS-1:0] obs_dtag;
  logic [TAG_BITS-1:0] obs_iresp;
  logic [TAG_BITS-1:0] obs_dresp;

  mem_bus_arbiter #(
    .TAG_BITS(TAG_BITS),
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_BITS(CNT_BITS)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .Icache2mem_command (Icache2mem_command),
    .Icache2mem_addr    (Icache2mem_addr),
    .Dcache2mem_command (Dcache2mem_command),
    .Dcache2mem_addr    (Dcache2mem_addr),
    .Dcache2mem_data    (Dcache2mem_data),
    .proc2mem_command   (proc2mem_command),
    .proc2mem_addr      (proc2mem_addr),
    .proc2mem_data      (proc2mem_data),
    .mem2proc_response  (mem2proc_response),
    .mem2proc_data      (mem2proc_data),
    .mem2proc_tag       (mem2proc_tag),
    .mem2Icache_response(mem2Icache_response),
    .mem2Icache_data    (mem2Icache_data),
    .mem2Icache_tag     (mem2Icache_tag),
    .mem2Dcache_response(mem2Dcache_response),
    .mem2Dcache_data    (mem2Dcache_data),
    .mem2Dcache_tag     (mem2Dcache_tag),
    .arb_outstanding    (arb_outstanding),
    .arb_idle           (arb_idle),
    .arb_protocol_err   (arb_protocol_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic int modelOutstanding();
    int n = 0;
    for (int i = 0; i < ENTRIES; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_owner[i] = 1'b0;
    end
    m_starve = 0;
    m_err    = 1'b0;
  endtask

  // One clock cycle: drive inputs, check every output against the model, then advance the model.
  task automatic applyStimulus(input logic [1:0] icmd, input logic [63:0] iaddr,
                               input logic [1:0] dcmd, input logic [63:0] daddr,
                               input logic [63:0] ddata, input logic [TAG_BITS-1:0] resp,
                               input logic [63:0] mdata, input logic [TAG_BITS-1:0] mtag);
    bit i_act, d_act, i_wins, d_wins, hit, accepted, is_load;
    logic [1:0]  e_cmd;
    logic [63:0] e_addr, e_data;
    int          e_out;
    Icache2mem_command = icmd;
    Icache2mem_addr    = iaddr;
    Dcache2mem_command = dcmd;
    Dcache2mem_addr    = daddr;
    Dcache2mem_data    = ddata;
    mem2proc_response  = resp;
    mem2proc_data      = mdata;
    mem2proc_tag       = mtag;
    #2;
    i_act  = (icmd == 2'd1);
    d_act  = (dcmd == 2'd1) || (dcmd == 2'd2);
    i_wins = i_act && (!d_act || (m_starve >= STARVE_LIMIT));
    d_wins = d_act && !i_wins;
    e_cmd  = i_wins ? 2'd1 : (d_wins ? dcmd : 2'd0);
    e_addr = i_wins ? iaddr : (d_wins ? daddr : 64'd0);
    e_data = d_wins ? ddata : 64'd0;
    hit    = (mtag != '0) && m_valid[mtag];
    e_out  = modelOutstanding();
    checkOutput("p2m_cmd",  64'(proc2mem_command), 64'(e_cmd));
    checkOutput("p2m_addr", proc2mem_addr, e_addr);
    checkOutput("p2m_data", proc2mem_data, e_data);
    checkOutput("i_resp",   64'(mem2Icache_response), i_wins ? 64'(resp) : 64'd0);
    checkOutput("d_resp",   64'(mem2Dcache_response), d_wins ? 64'(resp) : 64'd0);
    checkOutput("i_tag",    64'(mem2Icache_tag), (hit && !m_owner[mtag]) ? 64'(mtag) : 64'd0);
    checkOutput("d_tag",    64'(mem2Dcache_tag), (hit && m_owner[mtag]) ? 64'(mtag) : 64'd0);
    checkOutput("i_data",   mem2Icache_data, mdata);
    checkOutput("d_data",   mem2Dcache_data, mdata);
    checkOutput("outstanding", 64'(arb_outstanding), 64'(e_out));
    checkOutput("proto_err", 64'(arb_protocol_err), 64'(m_err));
    checkOutput("idle", 64'(arb_idle), 64'((e_out == 0) && !i_act && !d_act));
    obs_addr     = proc2mem_addr;
    obs_p2m_data = proc2mem_data;
    obs_dc_data  = mem2Dcache_data;
    obs_itag     = mem2Icache_tag;
    obs_dtag     = mem2Dcache_tag;
    obs_iresp    = mem2Icache_response;
    obs_dresp    = mem2Dcache_response;
    @(posedge clock);
    accepted = (i_wins || d_wins) && (resp != '0);
    is_load  = (e_cmd == 2'd1);
    if ((mtag != '0) && !m_valid[mtag]) m_err = 1'b1;
    if (accepted && is_load && m_valid[resp] && !(hit && (mtag == resp))) m_err = 1'b1;
    if (hit) m_valid[mtag] = 1'b0;
    if (accepted && is_load) begin
      m_valid[resp] = 1'b1;
      m_owner[resp] = d_wins;
    end
    if (i_act) begin
      if (i_wins && accepted) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve++;
    end
    #1;
  endtask

  task automatic idleCycle(input logic [TAG_BITS-1:0] mtag, input logic [63:0] mdata);
    applyStimulus(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, '0, mdata, mtag);
  endtask

  // Raise reset between clock edges with both requesters and a completion active.
  task automatic resetDut();
    Icache2mem_command = 2'd1;
    Dcache2mem_command = 2'd1;
    mem2proc_response  = 4'd3;
    mem2proc_tag       = 4'd5;
    reset = 1'b1;
    #1;
    checkOutput("rst_outstanding", 64'(arb_outstanding), 64'd0);
    checkOutput("rst_idle",        64'(arb_idle), 64'd1);
    checkOutput("rst_err",         64'(arb_protocol_err), 64'd0);
    checkOutput("rst_cmd",         64'(proc2mem_command), 64'd0);
    checkOutput("rst_i_resp",      64'(mem2Icache_response), 64'd0);
    checkOutput("rst_d_resp",      64'(mem2Dcache_response), 64'd0);
    checkOutput("rst_i_tag",       64'(mem2Icache_tag), 64'd0);
    checkOutput("rst_d_tag",       64'(mem2Dcache_tag), 64'd0);
    modelReset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [TAG_BITS-1:0] pickFree();
    for (int k = 0; k < 20; k++) begin
      int t = int'($urandom_range(1, ENTRIES-1));
      if (!m_valid[t]) return TAG_BITS'(t);
    end
    return '0;
  endfunction

  function automatic logic [TAG_BITS-1:0] pickValid();
    for (int k = 0; k < 20; k++) begin
      int t = int'($urandom_range(1, ENTRIES-1));
      if (m_valid[t]) return TAG_BITS'(t);
    end
    return '0;
  endfunction

  initial begin
    reset              = 1'b0;
    Icache2mem_command = 2'd0;
    Icache2mem_addr    = '0;
    Dcache2mem_command = 2'd0;
    Dcache2mem_addr    = '0;
    Dcache2mem_data    = '0;
    mem2proc_response  = '0;
    mem2proc_data      = '0;
    mem2proc_tag       = '0;
    modelReset();
    #1;
    resetDut();

    // Dcache load accepted as tag 3, completed five cycles later.
    applyStimulus(2'd0, 64'd0, 2'd1, 64'h2000, 64'd0, 4'd3, 64'd0, 4'd0);
    checkOutput("t1_d_resp", 64'(obs_dresp), 64'd3);
    checkOutput("t1_out_one", 64'(arb_outstanding), 64'd1);
    repeat (4) idleCycle(4'd0, 64'd0);
    idleCycle(4'd3, 64'hDEAD);
    checkOutput("t1_d_tag", 64'(obs_dtag), 64'd3);
    checkOutput("t1_d_data", obs_dc_data, 64'hDEAD);
    checkOutput("t1_i_tag", 64'(obs_itag), 64'd0);
    checkOutput("t1_out_zero", 64'(arb_outstanding), 64'd0);

    // Both load every cycle: Dcache wins four times, Icache once, then Dcache again.
    resetDut();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'd1, 64'h1000, 2'd1, 64'h2000, 64'd0, 4'(k + 1), 64'd0, 4'd0);
      checkOutput("t2_winner", obs_addr, (k == 4) ? 64'h1000 : 64'h2000);
    end
    checkOutput("t2_no_err", 64'(arb_protocol_err), 64'd0);

    // Accepted store: data forwarded, no entry, later tag 7 is a protocol error.
    resetDut();
    applyStimulus(2'd0, 64'd0, 2'd2, 64'h3000, 64'hCAFEF00D, 4'd7, 64'd0, 4'd0);
    checkOutput("t3_store_data", obs_p2m_data, 64'hCAFEF00D);
    checkOutput("t3_no_entry", 64'(arb_outstanding), 64'd0);
    idleCycle(4'd7, 64'h77);
    checkOutput("t3_err", 64'(arb_protocol_err), 64'd1);

    // Tag 2 completes for the Icache while being reissued to the Dcache.
    resetDut();
    applyStimulus(2'd1, 64'h1100, 2'd0, 64'd0, 64'd0, 4'd2, 64'd0, 4'd0);
    applyStimulus(2'd0, 64'd0, 2'd1, 64'h2200, 64'd0, 4'd2, 64'h5555, 4'd2);
    checkOutput("t4_old_owner", 64'(obs_itag), 64'd2);
    checkOutput("t4_not_dcache", 64'(obs_dtag), 64'd0);
    checkOutput("t4_reissue_ok", 64'(arb_protocol_err), 64'd0);
    checkOutput("t4_still_live", 64'(arb_outstanding), 64'd1);
    idleCycle(4'd2, 64'h6666);
    checkOutput("t4_new_owner", 64'(obs_dtag), 64'd2);
    checkOutput("t4_icache_quiet", 64'(obs_itag), 64'd0);

    // Memory rejects three times; nothing recorded, and the idle Icache accrues no starvation.
    resetDut();
    repeat (3) begin
      applyStimulus(2'd0, 64'd0, 2'd1, 64'h2300, 64'd0, 4'd0, 64'd0, 4'd0);
      checkOutput("t5_rejected", 64'(obs_dresp), 64'd0);
      checkOutput("t5_no_entry", 64'(arb_outstanding), 64'd0);
    end
    applyStimulus(2'd1, 64'h1300, 2'd1, 64'h2300, 64'd0, 4'd1, 64'd0, 4'd0);
    checkOutput("t5_dcache_wins", obs_addr, 64'h2300);

    // Reset with three more tags outstanding, then a stale completion.
    applyStimulus(2'd0, 64'd0, 2'd1, 64'h2400, 64'd0, 4'd4, 64'd0, 4'd0);
    applyStimulus(2'd0, 64'd0, 2'd1, 64'h2500, 64'd0, 4'd5, 64'd0, 4'd0);
    applyStimulus(2'd0, 64'd0, 2'd1, 64'h2600, 64'd0, 4'd6, 64'd0, 4'd0);
    checkOutput("t6_before_reset", 64'(arb_outstanding), 64'd4);
    resetDut();
    idleCycle(4'd5, 64'h5);
    checkOutput("t6_stale_err", 64'(arb_protocol_err), 64'd1);

    // Random traffic with a well-behaved memory: fresh tags accepted, live tags completed.
    resetDut();
    for (int n = 0; n < 400; n++) begin
      logic [1:0]          icmd, dcmd;
      logic [TAG_BITS-1:0] resp, mtag;
      icmd = 2'($urandom_range(0, 2));
      dcmd = 2'($urandom_range(0, 2));
      resp = ($urandom_range(0, 9) < 7) ? pickFree() : '0;
      mtag = ($urandom_range(0, 9) < 4) ? pickValid() : '0;
      applyStimulus(icmd, {$urandom, $urandom}, dcmd, {$urandom, $urandom},
                    {$urandom, $urandom}, resp, {$urandom, $urandom}, mtag);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
